// File: rtl/sram_pkg.sv
// Shared types and idle pin levels for the multi-port SRAM controller.
package sram_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;

   localparam logic OE_N_IDLE = 1'b1;
   localparam logic WE_N_IDLE = 1'b1;
   localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts after the last advanced winner.
module rr_arbiter #(
   parameter int unsigned NCH = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] req,
   input  logic           advance,
   output logic [NCH-1:0] grant
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [IW-1:0] last_q;
   logic [IW-1:0] gnt_idx;
   logic          found;
   int            idx;

   always_comb begin
      grant   = '0;
      gnt_idx = last_q;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= int'(NCH); i++) begin
         idx = (int'(last_q) + i) % int'(NCH);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = IW'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= IW'(NCH - 1);
      end else if (advance && found) begin
         last_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/sram_mp_ctrl.sv
// Multi-channel asynchronous SRAM controller with round-robin arbitration and
// fully registered SRAM pins.
module sram_mp_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned NCH     = 2,
   parameter int unsigned AW      = 17,
   parameter int unsigned DW      = 16,
   parameter int unsigned RD_WAIT = 1,
   parameter int unsigned WR_WAIT = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NCH-1:0]        req,
   input  logic [NCH-1:0]        we,
   input  logic [NCH*DW/8-1:0]   be,
   input  logic [NCH*AW-1:0]     addr,
   input  logic [NCH*DW-1:0]     d,
   output logic [NCH-1:0]        ack,
   output logic [DW-1:0]         q,
   output logic [AW-1:0]         sram_addr,
   inout  wire  [DW-1:0]         sram_dq,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [DW/8-1:0]       sram_be_n
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t            state_q;
   logic [WAIT_W-1:0] cnt_q;
   logic              gnt_pend_q;
   logic [NCH-1:0]    gnt_oh_q;
   logic              we_q;
   logic [BW-1:0]     be_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     d_q;
   logic [NCH-1:0]    ack_q;
   logic [DW-1:0]     q_q;
   logic [AW-1:0]     sram_addr_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic [BW-1:0]     be_n_q;
   logic [DW-1:0]     dq_out_q;
   logic              dq_oe_q;

   logic [NCH-1:0]    grant;
   logic [IW-1:0]     win_idx;
   logic              advance;

   // Arbitrate only when idle with no grant already waiting to launch.
   assign advance = (state_q == IDLE) && !gnt_pend_q && (|req);

   rr_arbiter #(
      .NCH(NCH)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .advance (advance),
      .grant   (grant)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (grant[i]) win_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_pend_q  <= 1'b0;
         gnt_oh_q    <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         d_q         <= '0;
         ack_q       <= '0;
         q_q         <= '0;
         sram_addr_q <= '0;
         oe_n_q      <= OE_N_IDLE;
         we_n_q      <= WE_N_IDLE;
         be_n_q      <= '1;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (gnt_pend_q) begin
                  gnt_pend_q  <= 1'b0;
                  sram_addr_q <= addr_q;
                  if (we_q) begin
                     state_q  <= WR;
                     cnt_q    <= WAIT_W'(WR_WAIT);
                     oe_n_q   <= 1'b1;
                     we_n_q   <= 1'b0;
                     be_n_q   <= ~be_q;
                     dq_out_q <= d_q;
                     dq_oe_q  <= 1'b1;
                  end else begin
                     state_q <= RD;
                     cnt_q   <= WAIT_W'(RD_WAIT);
                     oe_n_q  <= 1'b0;
                     we_n_q  <= 1'b1;
                     be_n_q  <= '0;
                     dq_oe_q <= 1'b0;
                  end
               end else if (advance) begin
                  gnt_pend_q <= 1'b1;
                  gnt_oh_q   <= grant;
                  we_q       <= we[win_idx];
                  be_q       <= be[win_idx*BW +: BW];
                  addr_q     <= addr[win_idx*AW +: AW];
                  d_q        <= d[win_idx*DW +: DW];
               end
            end
            RD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - WAIT_W'(1);
               end else begin
                  q_q     <= sram_dq;
                  ack_q   <= gnt_oh_q;
                  state_q <= IDLE;
                  oe_n_q  <= OE_N_IDLE;
                  be_n_q  <= '1;
               end
            end
            WR: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - WAIT_W'(1);
               end else begin
                  // Ack in the turnaround cycle while the bus floats.
                  ack_q   <= gnt_oh_q;
                  state_q <= TURN;
                  we_n_q  <= WE_N_IDLE;
                  be_n_q  <= '1;
                  dq_oe_q <= 1'b0;
               end
            end
            TURN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign q         = q_q;
   assign sram_addr = sram_addr_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_be_n = be_n_q;
   assign sram_dq   = dq_oe_q ? dq_out_q : {DW{1'bz}};

endmodule
